// File: rtl/bkt_lvl_if.sv
// Control/store bundle for the backtrack-level sequencer.
// master: conflict/bin-switch side plus store; slave: bkt_lvl_ctrl.
interface bkt_lvl_if #(
  parameter int NUM_LVLS = 8,
  parameter int WIDTH_LVL_STATES = 11
);
  localparam int SW = WIDTH_LVL_STATES * NUM_LVLS;
  localparam int BW = WIDTH_LVL_STATES - 1;

  logic          start_i;
  logic [15:0]   max_lvl_i;
  logic [BW-1:0] cur_bin_num_i;
  logic [SW-1:0] lvl_states_i;
  logic          load_i;
  logic [SW-1:0] load_states_i;
  logic          busy_o;
  logic          done_o;
  logic [3:0]    bkt_lvl_o;
  logic [BW-1:0] bkt_bin_o;
  logic          other_bin_o;
  logic          unsat_o;
  logic          apply_bkt_o;
  logic          wr_states_o;
  logic [SW-1:0] lvl_states_o;

  modport master (
    output start_i, max_lvl_i,
    output cur_bin_num_i,
    output lvl_states_i,
    output load_i, load_states_i,
    input  busy_o, done_o,
    input  bkt_lvl_o, bkt_bin_o,
    input  other_bin_o, unsat_o,
    input  apply_bkt_o, wr_states_o,
    input  lvl_states_o
  );

  modport slave (
    input  start_i, max_lvl_i,
    input  cur_bin_num_i,
    input  lvl_states_i,
    input  load_i, load_states_i,
    output busy_o, done_o,
    output bkt_lvl_o, bkt_bin_o,
    output other_bin_o, unsat_o,
    output apply_bkt_o, wr_states_o,
    output lvl_states_o
  );
endinterface

// File: rtl/bkt_lvl_ctrl.sv
// Backtrack-level search and state-load sequencer for the level store.
// Ports: clk, rst (sync, active high), ctl (bkt_lvl_if.slave).
module bkt_lvl_ctrl #(
  parameter int NUM_LVLS = 8,
  parameter int WIDTH_LVL_STATES = 11
) (
  input  logic       clk,
  input  logic       rst,
  bkt_lvl_if.slave   ctl
);
  localparam int W  = WIDTH_LVL_STATES;
  localparam int SW = W * NUM_LVLS;
  localparam int BW = W - 1;
  localparam int IW = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;

  typedef enum logic [2:0] {
    IDLE, SCAN, APPLY, DONE, LOAD
  } state_t;

  state_t        state;
  logic [IW-1:0] idx;
  logic [IW-1:0] lvl_r;
  logic [BW-1:0] bin_r;
  logic [BW-1:0] cur_r;
  logic          unsat_r;
  logic          oth_r;
  logic          ld_pend;
  logic [SW-1:0] ld_q;

  logic [15:0]   eff;
  logic [W-1:0]  slc;

  // Level count clamped to the store depth.
  always_comb begin
    eff = ctl.max_lvl_i;
    if (ctl.max_lvl_i > 16'(NUM_LVLS))
      eff = 16'(NUM_LVLS);
  end

  assign slc =
    ctl.lvl_states_i[int'(idx)*W +: W];

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= IDLE;
      idx              <= '0;
      lvl_r            <= '0;
      bin_r            <= '0;
      cur_r            <= '0;
      unsat_r          <= 1'b0;
      oth_r            <= 1'b0;
      ld_pend          <= 1'b0;
      ld_q             <= '0;
      ctl.busy_o       <= 1'b0;
      ctl.done_o       <= 1'b0;
      ctl.bkt_lvl_o    <= '0;
      ctl.bkt_bin_o    <= '0;
      ctl.other_bin_o  <= 1'b0;
      ctl.unsat_o      <= 1'b0;
      ctl.apply_bkt_o  <= 1'b0;
      ctl.wr_states_o  <= 1'b0;
      ctl.lvl_states_o <= '0;
    end else begin
      ctl.done_o      <= 1'b0;
      ctl.apply_bkt_o <= 1'b0;
      ctl.wr_states_o <= 1'b0;
      unique case (state)
        IDLE: begin
          if (ctl.start_i) begin
            cur_r           <= ctl.cur_bin_num_i;
            unsat_r         <= 1'b0;
            oth_r           <= 1'b0;
            lvl_r           <= '0;
            bin_r           <= '0;
            ctl.bkt_lvl_o   <= '0;
            ctl.bkt_bin_o   <= '0;
            ctl.other_bin_o <= 1'b0;
            ctl.unsat_o     <= 1'b0;
            ctl.busy_o      <= 1'b1;
            if (ctl.load_i) begin
              ld_q    <= ctl.load_states_i;
              ld_pend <= 1'b1;
            end
            if (eff == 16'd0) begin
              unsat_r <= 1'b1;
              state   <= APPLY;
            end else begin
              idx   <= IW'(eff - 16'd1);
              state <= SCAN;
            end
          end else if (ctl.load_i) begin
            ld_q       <= ctl.load_states_i;
            ctl.busy_o <= 1'b1;
            state      <= LOAD;
          end
        end
        SCAN: begin
          if (ctl.load_i && !ld_pend) begin
            ld_q    <= ctl.load_states_i;
            ld_pend <= 1'b1;
          end
          if (!slc[0]) begin
            lvl_r <= idx;
            bin_r <= slc[W-1:1];
            state <= APPLY;
          end else if (idx == '0) begin
            unsat_r <= 1'b1;
            state   <= APPLY;
          end else begin
            idx <= idx - 1'b1;
          end
        end
        APPLY: begin
          if (ctl.load_i && !ld_pend) begin
            ld_q    <= ctl.load_states_i;
            ld_pend <= 1'b1;
          end
          // A different bin is left for the upper layer to switch.
          if (!unsat_r) begin
            if (bin_r == cur_r)
              ctl.apply_bkt_o <= 1'b1;
            else
              oth_r <= 1'b1;
          end
          state <= DONE;
        end
        DONE: begin
          ctl.done_o      <= 1'b1;
          ctl.other_bin_o <= oth_r;
          ctl.unsat_o     <= unsat_r;
          ctl.bkt_lvl_o   <= unsat_r ? 4'd0 : 4'(lvl_r);
          ctl.bkt_bin_o   <= unsat_r ? '0 : bin_r;
          if (ld_pend) begin
            state <= LOAD;
          end else begin
            ctl.busy_o <= 1'b0;
            state      <= IDLE;
          end
        end
        LOAD: begin
          ctl.wr_states_o  <= 1'b1;
          ctl.lvl_states_o <= ld_q;
          ld_pend          <= 1'b0;
          ctl.busy_o       <= 1'b0;
          state            <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_bkt_lvl_ctrl.sv
// Directed bench for bkt_lvl_ctrl.
// Drives the interface and checks latencies and results.
module tb_bkt_lvl_ctrl;
  localparam int N  = 8;
  localparam int W  = 11;
  localparam int SW = N * W;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  bkt_lvl_if #(.NUM_LVLS(N), .WIDTH_LVL_STATES(W)) b ();

  bkt_lvl_ctrl #(.NUM_LVLS(N), .WIDTH_LVL_STATES(W)) dut (
    .clk (clk),
    .rst (rst),
    .ctl (b)
  );

  int          ap_c, dn_c;
  logic [3:0]  r_lvl;
  logic [9:0]  r_bin;
  logic        r_oth, r_uns;

  task automatic chk(string tag,
                     logic [127:0] obs,
                     logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h",
             tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [SW-1:0] mk(
    logic [7:0] hb, logic [9:0] bin);
    logic [SW-1:0] v;
    v = '0;
    for (int i = 0; i < N; i++)
      v[i*W +: W] = {bin, hb[i]};
    return v;
  endfunction

  function automatic logic [SW-1:0] pat(
    logic [10:0] p);
    logic [SW-1:0] v;
    for (int i = 0; i < N; i++)
      v[i*W +: W] = p;
    return v;
  endfunction

  // Pulse start (accepted at edge 0), then
  // record apply/done cycles within a budget.
  task automatic run(logic [15:0] ml,
                     logic [9:0] cb,
                     logic ld);
    b.max_lvl_i     = ml;
    b.cur_bin_num_i = cb;
    b.start_i       = 1'b1;
    b.load_i        = ld;
    tick();
    b.start_i = 1'b0;
    b.load_i  = 1'b0;
    ap_c = 0;
    dn_c = 0;
    for (int c = 1; c <= 30; c++) begin
      tick();
      if (b.apply_bkt_o && ap_c == 0)
        ap_c = c;
      if (b.done_o) begin
        dn_c  = c;
        r_lvl = b.bkt_lvl_o;
        r_bin = b.bkt_bin_o;
        r_oth = b.other_bin_o;
        r_uns = b.unsat_o;
        break;
      end
    end
  endtask

  initial begin
    b.start_i       = 1'b0;
    b.load_i        = 1'b0;
    b.max_lvl_i     = '0;
    b.cur_bin_num_i = '0;
    b.lvl_states_i  = '0;
    b.load_states_i = '0;
    tick();
    tick();
    rst = 1'b0;
    chk("rst_busy", b.busy_o, 0);
    chk("rst_done", b.done_o, 0);
    chk("rst_lvl", b.bkt_lvl_o, 0);
    chk("rst_uns", b.unsat_o, 0);
    chk("rst_wr", b.wr_states_o, 0);
    chk("rst_st", b.lvl_states_o, 0);

    // 1: found at level 3 in same bin
    b.lvl_states_i = mk(8'b1111_0100, 10'd5);
    run(16'd8, 10'd5, 1'b0);
    chk("t1_apply", ap_c, 6);
    chk("t1_done", dn_c, 7);
    chk("t1_lvl", r_lvl, 3);
    chk("t1_bin", r_bin, 5);
    chk("t1_oth", r_oth, 0);
    chk("t1_uns", r_uns, 0);
    tick();
    chk("t1_hold", b.bkt_lvl_o, 3);
    chk("t1_idle", b.busy_o, 0);

    // 2a: all levels already backtracked
    b.lvl_states_i = mk(8'hFF, 10'd5);
    run(16'd8, 10'd5, 1'b0);
    chk("t2_done", dn_c, 10);
    chk("t2_apply", ap_c, 0);
    chk("t2_uns", r_uns, 1);
    chk("t2_lvl", r_lvl, 0);
    chk("t2_bin", r_bin, 0);

    // 2b: no active levels
    run(16'd0, 10'd5, 1'b0);
    chk("t2b_done", dn_c, 2);
    chk("t2b_uns", r_uns, 1);
    chk("t2b_apply", ap_c, 0);

    // 3: clamp to 8, other bin
    b.lvl_states_i = mk(8'h7F, 10'd9);
    run(16'd20, 10'd4, 1'b0);
    chk("t3_done", dn_c, 3);
    chk("t3_lvl", r_lvl, 7);
    chk("t3_bin", r_bin, 9);
    chk("t3_oth", r_oth, 1);
    chk("t3_uns", r_uns, 0);
    chk("t3_apply", ap_c, 0);

    // 4: start and load together
    b.lvl_states_i  = mk(8'h7F, 10'd5);
    b.load_states_i = pat(11'h2AB);
    run(16'd8, 10'd5, 1'b1);
    b.load_states_i = '0;
    chk("t4_done", dn_c, 3);
    chk("t4_apply", ap_c, 2);
    chk("t4_busy3", b.busy_o, 1);
    chk("t4_wr3", b.wr_states_o, 0);
    tick();
    chk("t4_wr", b.wr_states_o, 1);
    chk("t4_data", b.lvl_states_o,
        pat(11'h2AB));
    chk("t4_busy4", b.busy_o, 0);
    tick();
    chk("t4_wr_pulse", b.wr_states_o, 0);

    // 5: load alone in IDLE
    b.load_states_i = pat(11'h155);
    b.load_i = 1'b1;
    tick();
    b.load_i = 1'b0;
    b.load_states_i = '0;
    chk("t5_busy0", b.busy_o, 1);
    chk("t5_wr0", b.wr_states_o, 0);
    tick();
    chk("t5_wr1", b.wr_states_o, 1);
    chk("t5_busy1", b.busy_o, 0);
    chk("t5_data", b.lvl_states_o,
        pat(11'h155));
    tick();
    chk("t5_wr2", b.wr_states_o, 0);

    // load arriving mid-scan becomes pending
    b.lvl_states_i = mk(8'hFF, 10'd1);
    b.max_lvl_i = 16'd8;
    b.start_i = 1'b1;
    tick();
    b.start_i = 1'b0;
    tick();
    b.load_states_i = pat(11'h3C1);
    b.load_i = 1'b1;
    tick();
    b.load_i = 1'b0;
    b.load_states_i = pat(11'h001);
    dn_c = 0;
    for (int c = 3; c <= 30; c++) begin
      tick();
      if (b.done_o) begin
        dn_c = c;
        break;
      end
    end
    chk("pend_done", dn_c, 10);
    tick();
    chk("pend_wr", b.wr_states_o, 1);
    chk("pend_data", b.lvl_states_o,
        pat(11'h3C1));
    b.load_states_i = '0;

    // 6: reset during SCAN
    b.lvl_states_i = mk(8'hFF, 10'd5);
    b.max_lvl_i = 16'd8;
    b.start_i = 1'b1;
    tick();
    b.start_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("t6_busy", b.busy_o, 0);
    chk("t6_done", b.done_o, 0);
    chk("t6_uns", b.unsat_o, 0);
    chk("t6_st", b.lvl_states_o, 0);
    dn_c = 0;
    for (int c = 1; c <= 12; c++) begin
      tick();
      if (b.done_o || b.apply_bkt_o)
        dn_c = c;
    end
    chk("t6_quiet", dn_c, 0);
    b.lvl_states_i = mk(8'b1111_0100, 10'd5);
    run(16'd8, 10'd5, 1'b0);
    chk("t6_redo", dn_c, 7);
    chk("t6_lvl", r_lvl, 3);

    $display("test done: total=%0d bad=%0d",
             total, bad);
    $finish;
  end
endmodule

// File: doc/bkt_lvl_ctrl.md
Name: bkt_lvl_ctrl

Overview:
- Sequencer for the 8-level state store of the Sat Engine.
- On a conflict, walks the level states from the current maximum level downward to find the backtrack level: the highest level whose has_bkt flag is 0. It then drives the backtrack pulse into the store and reports the target level and bin.
- Also sequences state loads into the store when the engine switches bins.
- Sits between the conflict/bin-switch control logic and the level state store.

Parameters:
- NUM_LVLS, 8, number of levels held by the store (indices 0..NUM_LVLS-1).
- WIDTH_LVL_STATES, 11, bits per level slice: [10:1] dcd_bin, [0] has_bkt.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous active-high reset.
- start_i  input  1  one-cycle pulse: begin backtrack-level search.
- max_lvl_i  input  16  number of active levels; sampled with start_i.
- cur_bin_num_i  input  10  bin currently loaded in the engine; sampled with start_i.
- lvl_states_i  input  WIDTH_LVL_STATES*NUM_LVLS  state read-back from the store; level 0 in LSB slice.
- load_i  input  1  one-cycle pulse: load new level states.
- load_states_i  input  WIDTH_LVL_STATES*NUM_LVLS  states to load; sampled with load_i.
- busy_o  output  1  high in every non-IDLE state.
- done_o  output  1  one-cycle pulse: search finished.
- bkt_lvl_o  output  4  found level index; valid with done_o.
- bkt_bin_o  output  10  dcd_bin of the found level; valid with done_o.
- other_bin_o  output  1  found level belongs to a bin other than cur_bin; valid with done_o.
- unsat_o  output  1  no level with has_bkt=0 exists; valid with done_o.
- apply_bkt_o  output  1  one-cycle backtrack strobe to the store.
- wr_states_o  output  1  one-cycle write strobe to the store.
- lvl_states_o  output  WIDTH_LVL_STATES*NUM_LVLS  data for the store write; valid with wr_states_o.

Behaviour:
- Clock and reset: one clock (clk), synchronous active-high reset (rst).
- Reset value of every output is 0. On reset the FSM goes to IDLE and the load-pending flag clears. This applies mid-operation as well: no done_o, apply_bkt_o or wr_states_o is issued for the aborted operation.
- All outputs are registered.
- FSM states: IDLE, SCAN, APPLY, DONE, LOAD.
- IDLE:
  - start_i=1: latch eff = min(max_lvl_i, NUM_LVLS) and cur_bin_num_i.
    - If eff=0: set unsat and go to APPLY.
    - Otherwise set idx=eff-1 and go to SCAN.
  - load_i=1 with start_i=0: latch load_states_i and go to LOAD.
  - start_i and load_i in the same cycle: start wins; load_states_i is latched and load_pending is set.
- SCAN, one slice examined per cycle:
  - slice[idx].has_bkt=0: record bkt_lvl=idx and bkt_bin=slice[idx].dcd_bin, go to APPLY.
  - has_bkt=1 and idx=0: set unsat and go to APPLY.
  - Otherwise decrement idx and stay in SCAN.
- APPLY (one cycle):
  - If found and bkt_bin equals the latched cur_bin: assert apply_bkt_o.
  - If found and bkt_bin differs: apply_bkt_o stays 0 and other_bin is set (the bin switch is left to the upper layer).
  - If unsat: apply_bkt_o stays 0.
  - Next state: DONE.
- DONE:
  - done_o=1 for one cycle. bkt_lvl_o, bkt_bin_o, other_bin_o and unsat_o are driven for this cycle.
  - When unsat, bkt_lvl_o and bkt_bin_o are 0.
  - Next state is LOAD if load_pending, else IDLE.
- LOAD (one cycle):
  - wr_states_o=1 and lvl_states_o = latched states; load_pending clears.
  - Next state: IDLE.
- Result outputs hold their value until the next start_i is accepted. done_o, apply_bkt_o and wr_states_o are pulses.
- start_i and load_i pulses arriving while busy_o=1 are ignored. Exception: a load_i arriving during SCAN or APPLY sets load_pending and latches its data, but only if no load is already pending; otherwise it is dropped.
- Latency: start_i accepted at cycle 0. With k = number of slices examined (1..eff), apply_bkt_o is asserted at cycle k+1 and done_o at cycle k+2. When eff=0, done_o is at cycle 2.
- Load latency: wr_states_o is asserted 1 cycle after load_i is accepted in IDLE.
- lvl_states_i is read live every SCAN cycle. The store must not change during a search.

Test Plan:
1. Levels 0..7 has_bkt=0,0,1,0,1,1,1,1; max_lvl_i=8, all dcd_bin=5, cur_bin=5 -> SCAN examines 7,6,5,4,3 (k=5); apply_bkt_o at cycle 6; done_o at cycle 7 with bkt_lvl_o=3, bkt_bin_o=5, other_bin_o=0, unsat_o=0.
2. All has_bkt=1, max_lvl_i=8 -> done_o at cycle 10, unsat_o=1, apply_bkt_o never asserted. Separately, max_lvl_i=0 -> done_o at cycle 2 with unsat_o=1.
3. max_lvl_i=20, level 7 has_bkt=0 with dcd_bin=9, cur_bin=4 -> clamped to 8; bkt_lvl_o=7, bkt_bin_o=9, other_bin_o=1, apply_bkt_o stays 0, done_o at cycle 3.
4. start_i and load_i in the same cycle (load data pattern 0x2AB in every slice), search k=1 -> done_o at cycle 3, then wr_states_o at cycle 4 with lvl_states_o equal to the pattern.
5. load_i alone in IDLE -> wr_states_o exactly 1 cycle later; busy_o high for exactly 1 cycle.
6. rst asserted during SCAN -> next cycle busy_o=0, all outputs 0, no done_o; a new start_i is then accepted normally.
